apb_slave_mux_chk: RTL and testbench



---
 rtl/apb_slave_mux_chk.sv | 170 +++++++++++++++++
 tb/tb_apb_slave_mux_chk.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mux_chk.sv
// APB3/APB4 single-master to N-slave interconnect with address decode, response mux and wait-state timeout.
// Define APB_PROTOCOL_CHECK_EN to build the sticky protocol checker behind proto_err.
module apb_slave_mux_chk #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SLAVE_NUM  = 8,
    parameter int SLOT_BITS  = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                            pclk,
    input  logic                            preset_n,
    input  logic                            m_psel,
    input  logic                            m_penable,
    input  logic                            m_pwrite,
    input  logic [ADDR_WIDTH-1:0]           m_paddr,
    input  logic [DATA_WIDTH-1:0]           m_pwdata,
    input  logic [DATA_WIDTH/8-1:0]         m_pstrb,
    input  logic [2:0]                      m_pprot,
    output logic [DATA_WIDTH-1:0]           m_prdata,
    output logic                            m_pready,
    output logic                            m_pslverr,
    output logic [SLAVE_NUM-1:0]            s_psel,
    output logic                            s_penable,
    output logic                            s_pwrite,
    output logic [ADDR_WIDTH-1:0]           s_paddr,
    output logic [DATA_WIDTH-1:0]           s_pwdata,
    output logic [DATA_WIDTH/8-1:0]         s_pstrb,
    output logic [2:0]                      s_pprot,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0] s_prdata,
    input  logic [SLAVE_NUM-1:0]            s_pready,
    input  logic [SLAVE_NUM-1:0]            s_pslverr,
    output logic                            err_decode,
    output logic                            err_timeout,
    output logic [ADDR_WIDTH-1:0]           last_err_addr,
    input  logic                            clr_err,
    output logic [3:0]                      proto_err
);
    localparam int IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
    localparam int HI    = SLOT_BITS + IDX_W;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT} phase_t;

    phase_t                phase;
    logic [IDX_W-1:0]      idx;
    logic                  hit;
    logic                  setup_now;
    logic                  access_now;
    logic                  timeout_now;
    logic [CNT_W-1:0]      cnt;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    assign s_penable = m_penable;
    assign s_pwrite  = m_pwrite;
    assign s_paddr   = m_paddr;
    assign s_pwdata  = m_pwdata;
    assign s_pstrb   = m_pstrb;
    assign s_pprot   = m_pprot;

    assign idx        = m_paddr[SLOT_BITS +: IDX_W];
    assign hit        = ({1'b0, idx} < (IDX_W + 1)'(SLAVE_NUM)) && ((m_paddr >> HI) == '0);
    assign setup_now  = m_psel && !m_penable;
    assign access_now = m_psel && m_penable;
    assign timeout_now = (TIMEOUT != 0) && access_now && hit && (cnt == CNT_W'(TIMEOUT));

    always_comb begin
        s_psel    = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (hit && idx == IDX_W'(i)) begin
                s_psel[i] = m_psel;
                sel_ready = s_pready[i];
                sel_err   = s_pslverr[i];
                sel_rdata = s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Misses and timeouts terminate locally with an error and zero data.
    always_comb begin
        m_prdata  = '0;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        if (m_psel) begin
            if (!hit) begin
                m_pready  = m_penable;
                m_pslverr = m_penable;
            end else if (timeout_now) begin
                m_pready  = 1'b1;
                m_pslverr = 1'b1;
            end else begin
                m_prdata  = sel_rdata;
                m_pready  = sel_ready;
                m_pslverr = sel_err;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            phase         <= IDLE;
            cnt           <= '0;
            err_decode    <= 1'b0;
            err_timeout   <= 1'b0;
            last_err_addr <= '0;
        end else begin
            case (phase)
                IDLE:    if (setup_now) phase <= SETUP;
                default: begin
                    if (access_now && !m_pready) phase <= WAIT;
                    else if (setup_now)          phase <= SETUP;
                    else                         phase <= IDLE;
                end
            endcase
            if (setup_now)
                cnt <= '0;
            else if (TIMEOUT != 0 && access_now && hit && !sel_ready && cnt != CNT_W'(TIMEOUT))
                cnt <= cnt + CNT_W'(1);
            err_decode  <= access_now && !hit;
            err_timeout <= timeout_now;
            if (access_now && (!hit || timeout_now))
                last_err_addr <= m_paddr;
        end
    end

`ifdef APB_PROTOCOL_CHECK_EN
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic                    cap_write;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [DATA_WIDTH/8-1:0] cap_strb;
    logic [3:0]              viol;

    always_comb begin
        viol[0] = m_penable && (phase == IDLE);
        viol[1] = (phase == SETUP) && !access_now;
        viol[2] = access_now && (phase != IDLE) &&
                  (m_paddr != cap_addr || m_pwrite != cap_write ||
                   m_pwdata != cap_wdata || m_pstrb != cap_strb);
        viol[3] = (phase == WAIT) && !m_psel;
    end

    // A violation in the same cycle as clr_err survives the clear.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            proto_err <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_strb  <= '0;
        end else begin
            if (setup_now) begin
                cap_addr  <= m_paddr;
                cap_write <= m_pwrite;
                cap_wdata <= m_pwdata;
                cap_strb  <= m_pstrb;
            end
            proto_err <= (clr_err ? 4'b0000 : proto_err) | viol;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_err;
    assign proto_err  = 4'b0000;
`endif

endmodule

// File: tb/tb_apb_slave_mux_chk.sv
// Randomized self-checking bench for apb_slave_mux_chk against a transaction-level reference model.
module tb_apb_slave_mux_chk;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SN = 4;
    localparam int SB = 12;
    localparam int TO = 16;

    logic            pclk = 1'b0;
    logic            preset_n;
    logic            m_psel, m_penable, m_pwrite;
    logic [AW-1:0]   m_paddr;
    logic [DW-1:0]   m_pwdata;
    logic [DW/8-1:0] m_pstrb;
    logic [2:0]      m_pprot;
    logic [DW-1:0]   m_prdata;
    logic            m_pready, m_pslverr;
    logic [SN-1:0]   s_psel;
    logic            s_penable, s_pwrite;
    logic [AW-1:0]   s_paddr;
    logic [DW-1:0]   s_pwdata;
    logic [DW/8-1:0] s_pstrb;
    logic [2:0]      s_pprot;
    logic [SN*DW-1:0] s_prdata;
    logic [SN-1:0]   s_pready, s_pslverr;
    logic            err_decode, err_timeout;
    logic [AW-1:0]   last_err_addr;
    logic            clr_err;
    logic [3:0]      proto_err;

    apb_slave_mux_chk #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_NUM(SN), .SLOT_BITS(SB), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .preset_n(preset_n),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .err_decode(err_decode), .err_timeout(err_timeout), .last_err_addr(last_err_addr),
        .clr_err(clr_err), .proto_err(proto_err)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Expected-state of the reference model
    bit            pend = 1'b0;
    bit            pend_dec, pend_to;
    logic [AW-1:0] model_last = '0;
    logic [3:0]    exp_proto = 4'b0000;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic randomize_slaves();
        s_prdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_pready  = 4'($urandom());
        s_pslverr = 4'($urandom());
    endtask

    task automatic check_pending();
        chk("err_decode", err_decode, pend_dec);
        chk("err_timeout", err_timeout, pend_to);
        chk("last_err_addr", last_err_addr, model_last);
        chk("proto_err", proto_err, exp_proto);
        pend = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            m_psel = 1'b0; m_penable = 1'b0;
            randomize_slaves();
            #1;
            if (pend) check_pending();
            else begin
                chk("idle_errs", {err_decode, err_timeout}, 2'b00);
                chk("idle_proto", proto_err, exp_proto);
            end
            chk("idle_pready", m_pready, 1'b0);
            chk("idle_sel", s_psel, 4'b0000);
        end
    endtask

    // One full APB transfer; the slave at the decoded region inserts 'waits' wait cycles.
    task automatic xfer(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata, input bit serr);
        longint region;
        bit     miss, tmo;
        int     tgt, done_at;
        logic [SN-1:0] exp_sel;
        region  = longint'(addr) / 4096;
        miss    = region >= SN;
        tgt     = miss ? 0 : int'(region);
        tmo     = !miss && waits >= TO;
        done_at = miss ? 1 : (tmo ? TO + 1 : waits + 1);
        exp_sel = miss ? '0 : SN'(1 << tgt);

        @(negedge pclk);
        m_psel = 1'b1; m_penable = 1'b0; m_paddr = addr; m_pwrite = wr; m_pwdata = wdata;
        m_pstrb = 4'($urandom()); m_pprot = 3'($urandom());
        randomize_slaves();
        #1;
        if (pend) check_pending();
        chk("s_psel_setup", s_psel, exp_sel);
        chk("s_paddr", s_paddr, addr);
        chk("s_pwdata", s_pwdata, wdata);
        chk("s_pwrite", s_pwrite, wr);
        chk("s_pstrb", s_pstrb, m_pstrb);
        chk("s_pprot", s_pprot, m_pprot);

        for (int k = 1; k <= done_at; k++) begin
            @(negedge pclk);
            m_penable = 1'b1;
            randomize_slaves();
            if (!miss) begin
                s_pready[tgt]           = (k > waits);
                s_pslverr[tgt]          = serr;
                s_prdata[tgt*DW +: DW]  = rdata;
            end
            #1;
            chk("m_pready", m_pready, (k == done_at));
        end
        chk("m_pslverr", m_pslverr, miss || tmo || serr);
        chk("m_prdata", m_prdata, (miss || tmo) ? 32'h0 : rdata);
        chk("s_psel_access", s_psel, exp_sel);
        chk("s_penable", s_penable, 1'b1);

        pend     = 1'b1;
        pend_dec = miss;
        pend_to  = tmo;
        if (miss || tmo) model_last = addr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        preset_n = 1'b0; clr_err = 1'b0;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_pstrb = '0; m_pprot = '0;
        randomize_slaves();
        repeat (2) @(negedge pclk);
        #1;
        chk("rst_err_decode", err_decode, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        chk("rst_last_err_addr", last_err_addr, 32'h0);
        chk("rst_proto_err", proto_err, 4'b0000);
        chk("rst_pready", m_pready, 1'b0);
        m_psel = 1'b1; m_paddr = 32'h0000_2004;
        #1;
        chk("rst_comb_sel", s_psel, 4'b0100);
        m_psel = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;

        xfer(32'h0000_2004, 1'b1, 32'hA5A5_0001, 0, $urandom(), 1'b0);
        idle(1);
        xfer(32'h0000_1008, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0);
        idle(1);
        xfer(32'h0000_5000, 1'b0, 32'h0, 0, $urandom(), 1'b0);
        xfer(32'h1000_0000, 1'b0, 32'h0, 0, $urandom(), 1'b0);
        idle(1);
        chk("last_err_after_decode", last_err_addr, 32'h1000_0000);
        xfer(32'h0000_3000, 1'b0, 32'h0, 1000, $urandom(), 1'b0);
        idle(2);

        // Reset asserted while slave 0 is stalling.
        @(negedge pclk);
        m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h0000_0010; m_pwrite = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            m_penable = 1'b1; randomize_slaves(); s_pready[0] = 1'b0;
            #1;
            chk("pre_rst_wait", m_pready, 1'b0);
        end
        @(negedge pclk);
        preset_n = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
        #1;
        model_last = '0;
        chk("midrst_last_err", last_err_addr, 32'h0);
        chk("midrst_errs", {err_decode, err_timeout}, 2'b00);
        chk("midrst_proto", proto_err, 4'b0000);
        @(negedge pclk);
        preset_n = 1'b1;
        xfer(32'h0000_0020, 1'b0, 32'h0, 15, 32'hCAFE_0020, 1'b0);
        idle(1);

        // Address changes in the middle of ACCESS.
        @(negedge pclk);
        m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h0000_1008; m_pwrite = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge pclk);
            m_penable = 1'b1; m_paddr = 32'h0000_1010;
            randomize_slaves(); s_pready[1] = (k == 3);
            #1;
            chk("chg_pready", m_pready, (k == 3));
        end
`ifdef APB_PROTOCOL_CHECK_EN
        exp_proto = 4'b0100;
`else
        exp_proto = 4'b0000;
`endif
        idle(2);
        @(negedge pclk);
        clr_err = 1'b1;
        @(negedge pclk);
        clr_err = 1'b0;
        exp_proto = 4'b0000;
        #1;
        chk("proto_cleared", proto_err, 4'b0000);
        idle(1);

        for (int n = 0; n < 150; n++) begin
            logic [AW-1:0] addr;
            int            w, r;
            if ($urandom_range(0, 9) < 8)
                addr = {18'h0, 2'($urandom_range(0, SN - 1)), 10'($urandom()), 2'b00};
            else
                addr = $urandom();
            r = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 4);
            else if (r == 7) w = 15;
            else if (r == 8) w = 16;
            else             w = $urandom_range(17, 20);
            xfer(addr, 1'($urandom()), $urandom(), w, $urandom(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
